// File: rtl/ofm_drain.sv
// ofm_drain: sequences the systolic array shift-out, captures column words
// into a small FIFO (optional ReLU on the way in), streams them to the OFM
// buffer writer over valid/ready and pulses reset_pe once the tile is done.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   drain_start         1-cycle pulse to begin a drain (ignored while busy)
//   relu_en             sampled with an accepted drain_start
//   drain_busy          high while a drain is in progress
//   drain_done          1-cycle pulse when the tile is delivered and cleared
//   write_out_en        to array: shift the mac chain one column
//   reset_pe            to array: 1-cycle accumulator clear
//   ofm_in              column word from the array, valid 1 cycle after write_out_en
//   m_valid/m_ready     output handshake
//   m_data/m_col/m_last output word, its column index, last-column flag
module ofm_drain #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned SYSTOLIC_SIZE = 16,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  drain_start,
    input  logic                                  relu_en,
    output logic                                  drain_busy,
    output logic                                  drain_done,
    output logic                                  write_out_en,
    output logic                                  reset_pe,
    input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]   ofm_in,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]   m_data,
    output logic [$clog2(SYSTOLIC_SIZE)-1:0]      m_col,
    output logic                                  m_last
);

    localparam int unsigned WordW = SYSTOLIC_SIZE * DATA_WIDTH;
    localparam int unsigned ColW  = $clog2(SYSTOLIC_SIZE);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned OccW  = CntW + 1;

    localparam logic [ColW-1:0] LastCol = ColW'(SYSTOLIC_SIZE - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StClear = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [ColW-1:0] issue_cnt_q;
    logic            relu_q;
    logic            inflight_q;
    logic [ColW-1:0] cap_col_q;
    logic            last_popped_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic [WordW-1:0] mem_data [FIFO_DEPTH];
    logic [ColW-1:0]  mem_col  [FIFO_DEPTH];

    logic             fifo_empty;
    logic             push, pop;
    logic             start_acc;
    logic [OccW-1:0]  occupancy;
    logic [WordW-1:0] cap_data;

    assign fifo_empty = (count_q == '0);
    assign push       = inflight_q;
    assign pop        = !fifo_empty && m_ready;
    assign start_acc  = (state_q == StIdle) && drain_start;

    // Words already in the FIFO plus the one still coming out of the array.
    // A same-cycle pop is deliberately not credited.
    assign occupancy    = OccW'(count_q) + OccW'(inflight_q);
    assign write_out_en = (state_q == StShift) && (occupancy < OccW'(FIFO_DEPTH));

    assign drain_busy = (state_q != StIdle);
    assign drain_done = (state_q == StClear);
    assign reset_pe   = (state_q == StClear);

    // Head is gated so the data outputs read 0 whenever nothing is offered.
    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : mem_data[rd_ptr_q];
    assign m_col   = fifo_empty ? '0 : mem_col[rd_ptr_q];
    assign m_last  = m_valid && (m_col == LastCol);

    // ReLU: clamp negative lanes when the latched enable is set.
    always_comb begin
        cap_data = ofm_in;
        for (int r = 0; r < int'(SYSTOLIC_SIZE); r++) begin
            if (relu_q && ofm_in[r*DATA_WIDTH + DATA_WIDTH - 1]) begin
                cap_data[r*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (drain_start) state_d = StShift;
            StShift: if (write_out_en && (issue_cnt_q == LastCol)) state_d = StWait;
            StWait:  if (fifo_empty && !inflight_q && last_popped_q) state_d = StClear;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            issue_cnt_q   <= '0;
            relu_q        <= 1'b0;
            inflight_q    <= 1'b0;
            cap_col_q     <= '0;
            last_popped_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= write_out_en;
            if (start_acc) begin
                issue_cnt_q   <= '0;
                relu_q        <= relu_en;
                last_popped_q <= 1'b0;
            end else if (write_out_en) begin
                issue_cnt_q <= issue_cnt_q + ColW'(1);
            end
            // Column tag travels with the in-flight word.
            if (write_out_en) cap_col_q <= issue_cnt_q;
            if (pop && (mem_col[rd_ptr_q] == LastCol)) last_popped_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= cap_data;
            mem_col[wr_ptr_q]  <= cap_col_q;
        end
    end

endmodule
